// File: rtl/led_pattern_engine.sv
// LED pattern engine: captures the LED register block on each write strobe and
// drives static, blink or chase patterns with 8-bit PWM and optional inversion.
module led_pattern_engine #(
  parameter int NUM_LEDS = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [31:0]         ctrl_reg,
  input  logic [31:0]         pattern_reg,
  input  logic [31:0]         duty_reg,
  input  logic [31:0]         period_reg,
  input  logic                reg_update,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick,
  output logic [1:0]          state
);

  // state   | meaning
  // IDLE    | disabled, LEDs held at their inactive level
  // STATIC  | pattern shown continuously
  // BLINK   | pattern shown on alternate steps
  // CHASE   | pattern rotated left by one LED per step
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_BLINK  = 2'd2,
    ST_CHASE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          sh_ctrl_q, sh_ctrl_d;
  logic [NUM_LEDS-1:0] sh_pat_q, sh_pat_d;
  logic [7:0]          sh_duty_q, sh_duty_d;
  logic [PERIOD_W-1:0] sh_per_q, sh_per_d;
  logic                restart_q, restart_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [7:0]          pwm_q, pwm_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] chase_q, chase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  logic [PERIOD_W-1:0] period_last;
  logic                tick_c;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] raw;

  // Only the low fields of each register are meaningful.
  logic unused_inputs;
  assign unused_inputs = ^{ctrl_reg, pattern_reg, duty_reg, period_reg};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart_q) begin
      if (!sh_ctrl_q[0]) begin
        state_d = ST_IDLE;
      end else begin
        case (sh_ctrl_q[2:1])
          2'd1:    state_d = ST_BLINK;
          2'd2:    state_d = ST_CHASE;
          default: state_d = ST_STATIC;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sh_ctrl_q <= '0;
      sh_pat_q  <= '0;
      sh_duty_q <= '0;
      sh_per_q  <= '0;
      restart_q <= 1'b0;
      presc_q   <= '0;
      pwm_q     <= '0;
      phase_q   <= 1'b0;
      chase_q   <= '0;
      led_q     <= '0;
    end else begin
      sh_ctrl_q <= sh_ctrl_d;
      sh_pat_q  <= sh_pat_d;
      sh_duty_q <= sh_duty_d;
      sh_per_q  <= sh_per_d;
      restart_q <= restart_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      phase_q   <= phase_d;
      chase_q   <= chase_d;
      led_q     <= led_d;
    end
  end

  // A zero period behaves as one, so the step ticks every cycle.
  assign period_last = (sh_per_q == '0) ? '0 : sh_per_q - PERIOD_W'(1);
  assign tick_c      = (state_q != ST_IDLE) && (presc_q == period_last);

  always_comb begin
    sh_ctrl_d = sh_ctrl_q;
    sh_pat_d  = sh_pat_q;
    sh_duty_d = sh_duty_q;
    sh_per_d  = sh_per_q;
    restart_d = reg_update;
    if (reg_update) begin
      sh_ctrl_d = ctrl_reg[3:0];
      sh_pat_d  = pattern_reg[NUM_LEDS-1:0];
      sh_duty_d = duty_reg[7:0];
      sh_per_d  = period_reg[PERIOD_W-1:0];
    end

    presc_d = '0;
    pwm_d   = '0;
    phase_d = phase_q;
    chase_d = chase_q;
    if (restart_q) begin
      // Restart takes priority over a coincident step: no toggle, no rotate.
      phase_d = 1'b1;
      chase_d = sh_pat_q;
    end else if (state_q != ST_IDLE) begin
      presc_d = tick_c ? '0 : presc_q + PERIOD_W'(1);
      pwm_d   = pwm_q + 8'd1;
      if (tick_c) begin
        phase_d = ~phase_q;
        if (state_q == ST_CHASE) begin
          chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
        end
      end
    end
  end

  // led_out is built from next-state values so the register lines up with them.
  always_comb begin
    raw = '0;
    case (state_d)
      ST_STATIC: raw = sh_pat_q;
      ST_BLINK:  raw = phase_d ? sh_pat_q : '0;
      ST_CHASE:  raw = chase_d;
      default:   raw = '0;
    endcase
    pwm_on = (state_d != ST_IDLE) && ((pwm_d < sh_duty_q) || (sh_duty_q == 8'hFF));
    led_d  = (raw & {NUM_LEDS{pwm_on}}) ^ {NUM_LEDS{sh_ctrl_q[3]}};
  end

  assign led_out = led_q;
  assign tick    = tick_c;
  assign state   = state_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine with hand-computed
// expectations for reset, static, blink, chase, PWM, invert and restart cases.
module tb_led_pattern_engine;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] ctrl_reg;
  logic [31:0] pattern_reg;
  logic [31:0] duty_reg;
  logic [31:0] period_reg;
  logic        reg_update;
  logic [3:0]  led_out;
  logic        tick;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_engine #(.NUM_LEDS(4), .PERIOD_W(24)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .ctrl_reg    (ctrl_reg),
    .pattern_reg (pattern_reg),
    .duty_reg    (duty_reg),
    .period_reg  (period_reg),
    .reg_update  (reg_update),
    .led_out     (led_out),
    .tick        (tick),
    .state       (state)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Pulse reg_update for one cycle; returns at the first cycle led_out shows the load.
  task automatic load(input logic [31:0] c, input logic [31:0] p,
                      input logic [31:0] d, input logic [31:0] per);
    ctrl_reg    = c;
    pattern_reg = p;
    duty_reg    = d;
    period_reg  = per;
    reg_update  = 1'b1;
    step(1);
    reg_update  = 1'b0;
    step(1);
  endtask

  initial begin
    logic [3:0] seq_a [0:4];
    logic [3:0] seq_b [0:4];
    int cnt_on, cnt_tick, first_tick, last_tick, first_off;

    seq_a[0] = 4'h1; seq_a[1] = 4'h2; seq_a[2] = 4'h4; seq_a[3] = 4'h8; seq_a[4] = 4'h1;
    seq_b[0] = 4'h9; seq_b[1] = 4'h3; seq_b[2] = 4'h6; seq_b[3] = 4'hC; seq_b[4] = 4'h9;

    ARESET      = 1'b1;
    ctrl_reg    = '0;
    pattern_reg = '0;
    duty_reg    = '0;
    period_reg  = '0;
    reg_update  = 1'b0;
    step(5);
    check_val("reset_led",   32'(led_out), 32'h0);
    check_val("reset_tick",  32'(tick),    32'h0);
    check_val("reset_state", 32'(state),   32'h0);
    ARESET = 1'b0;
    step(2);
    check_val("idle_led", 32'(led_out), 32'h0);

    // Static, period 16; later input changes without a strobe must be ignored
    load(32'h1, 32'hA, 32'hFF, 32'h10);
    check_val("static_state", 32'(state),   32'h1);
    check_val("static_led",   32'(led_out), 32'hA);
    ctrl_reg    = 32'h0;
    pattern_reg = 32'h5;
    cnt_on = 0; cnt_tick = 0; first_tick = -1; last_tick = -1;
    for (int i = 0; i < 100; i++) begin
      if (led_out == 4'hA) cnt_on++;
      if (tick) begin
        cnt_tick++;
        if (first_tick < 0) first_tick = i;
        last_tick = i;
      end
      step(1);
    end
    check_val("static_steady",     32'(cnt_on),     32'd100);
    check_val("static_tick_count", 32'(cnt_tick),   32'd6);
    check_val("static_tick_first", 32'(first_tick), 32'd15);
    check_val("static_tick_last",  32'(last_tick),  32'd95);

    // Blink, period 4: four cycles on, four off
    load(32'h3, 32'hF, 32'hFF, 32'h4);
    check_val("blink_state", 32'(state), 32'h2);
    for (int j = 0; j < 12; j++) begin
      check_val($sformatf("blink_led_%0d", j), 32'(led_out),
                (((j / 4) % 2) == 0) ? 32'hF : 32'h0);
      step(1);
    end

    // Chase, period 1
    load(32'h5, 32'h1, 32'hFF, 32'h1);
    check_val("chase_state", 32'(state), 32'h3);
    check_val("chase_tick",  32'(tick),  32'h1);
    for (int j = 0; j < 5; j++) begin
      check_val($sformatf("chase1_led_%0d", j), 32'(led_out), 32'(seq_a[j]));
      step(1);
    end
    load(32'h5, 32'h9, 32'hFF, 32'h1);
    for (int j = 0; j < 5; j++) begin
      check_val($sformatf("chase9_led_%0d", j), 32'(led_out), 32'(seq_b[j]));
      step(1);
    end

    // PWM duty 0x40 over a 256-cycle frame
    load(32'h1, 32'hF, 32'h40, 32'd1000);
    cnt_on = 0; first_off = -1;
    for (int i = 0; i < 256; i++) begin
      if (led_out == 4'hF) cnt_on++;
      else if (first_off < 0) first_off = i;
      step(1);
    end
    check_val("pwm40_on_count",  32'(cnt_on),    32'd64);
    check_val("pwm40_first_off", 32'(first_off), 32'd64);
    check_val("pwm40_wrap_on",   32'(led_out),   32'hF);

    load(32'h1, 32'hF, 32'h0, 32'd1000);
    cnt_on = 0;
    for (int i = 0; i < 256; i++) begin
      if (led_out != 4'h0) cnt_on++;
      step(1);
    end
    check_val("pwm00_on_count", 32'(cnt_on), 32'd0);

    load(32'h1, 32'hF, 32'hFF, 32'd1000);
    cnt_on = 0;
    for (int i = 0; i < 256; i++) begin
      if (led_out == 4'hF) cnt_on++;
      step(1);
    end
    check_val("pwmff_on_count", 32'(cnt_on), 32'd256);

    // Invert; a zero period ticks every cycle
    load(32'h9, 32'h3, 32'hFF, 32'h0);
    check_val("inv_state", 32'(state),   32'h1);
    check_val("inv_led",   32'(led_out), 32'hC);
    check_val("inv_tick",  32'(tick),    32'h1);
    load(32'h8, 32'h3, 32'hFF, 32'h0);
    check_val("inv_idle_state", 32'(state),   32'h0);
    check_val("inv_idle_led",   32'(led_out), 32'hF);
    check_val("inv_idle_tick",  32'(tick),    32'h0);

    // Strobe while chase ticks every cycle: reload, no extra rotation
    load(32'h5, 32'h1, 32'hFF, 32'h1);
    step(2);
    check_val("coll_pre_led", 32'(led_out), 32'h4);
    ctrl_reg    = 32'h5;
    pattern_reg = 32'h5;
    reg_update  = 1'b1;
    step(1);
    reg_update  = 1'b0;
    check_val("coll_led_old",  32'(led_out), 32'h8);
    check_val("coll_tick",     32'(tick),    32'h1);
    step(1);
    check_val("coll_reload",   32'(led_out), 32'h5);
    step(1);
    check_val("coll_rotate",   32'(led_out), 32'hA);

    // Reset in the middle of a chase
    ARESET = 1'b1;
    step(1);
    check_val("midrst_led",   32'(led_out), 32'h0);
    check_val("midrst_state", 32'(state),   32'h0);
    check_val("midrst_tick",  32'(tick),    32'h0);
    ARESET = 1'b0;
    step(3);
    check_val("postrst_led",   32'(led_out), 32'h0);
    check_val("postrst_state", 32'(state),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
